// File: rtl/ofdm_symbol_mapper_if.sv
// ofdm_symbol_mapper_if
// Groups the symbol-control, input bit-group and output sample signals of
// ofdm_symbol_mapper.
//   master : the side that requests symbols, supplies bit groups and
//            accepts samples (interleaver / IFFT wrapper, or a bench)
//   slave  : the mapper itself
// Signals:
//   frame_start, sym_start, sym_bpsc, sym_ready, sym_err   symbol control
//   in_valid, in_data, in_ready                            bit-group stream
//   out_valid, out_ready, out_i, out_q, out_bin,
//   out_kind, out_last                                     sample stream
interface ofdm_symbol_mapper_if #(
  parameter int OUT_W = 13
) ();
  logic                    frame_start;
  logic                    sym_start;
  logic [2:0]              sym_bpsc;
  logic                    sym_ready;
  logic                    sym_err;
  logic                    in_valid;
  logic [5:0]              in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic [5:0]              out_bin;
  logic [1:0]              out_kind;
  logic                    out_last;

  modport master (
    output frame_start, sym_start, sym_bpsc, in_valid, in_data, out_ready,
    input  sym_ready, sym_err, in_ready, out_valid, out_i, out_q, out_bin,
           out_kind, out_last
  );

  modport slave (
    input  frame_start, sym_start, sym_bpsc, in_valid, in_data, out_ready,
    output sym_ready, sym_err, in_ready, out_valid, out_i, out_q, out_bin,
           out_kind, out_last
  );
endinterface

// File: rtl/ofdm_symbol_mapper.sv
// ofdm_symbol_mapper
// 802.11a constellation mapper producing all 64 IFFT bins of one OFDM symbol.
// Data bins consume one bit group each (BPSK/QPSK/16-QAM/64-QAM, Gray coded),
// null bins (0, 27..37) emit zero, pilot bins (7, 21, 43, 57) emit +/-A_BPSK
// with the per-symbol polarity of the 127-long x^7+x^4+1 sequence.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ofdm_symbol_mapper_if.slave (symbol control, input, output streams)
// Build option:
//   OFDM_MAPPER_FFTSHIFT_EN  emit bins 32..63 then 0..31; out_last on bin 31
//
// state | meaning
// IDLE  | waiting for sym_start, sym_ready=1
// RUN   | stepping through the 64 bins of the current symbol
module ofdm_symbol_mapper #(
  parameter int OUT_W  = 13,
  parameter int A_BPSK = 2048,
  parameter int A_QPSK = 1448,
  parameter int Q16_L1 = 648,
  parameter int Q16_L3 = 1943,
  parameter int Q64_U  = 316
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ofdm_symbol_mapper_if.slave  bus
);

  localparam int AMP_MAX = (1 << (OUT_W - 1)) - 1;

  generate
    if (A_BPSK > AMP_MAX || A_QPSK > AMP_MAX || Q16_L1 > AMP_MAX ||
        Q16_L3 > AMP_MAX || 7 * Q64_U > AMP_MAX) begin : g_amp_chk
      $error("ofdm_symbol_mapper: amplitude does not fit OUT_W-1 magnitude bits");
    end
  endgenerate

  localparam logic signed [OUT_W-1:0] C_BPSK = OUT_W'(A_BPSK);
  localparam logic signed [OUT_W-1:0] C_QPSK = OUT_W'(A_QPSK);
  localparam logic signed [OUT_W-1:0] C_L1   = OUT_W'(Q16_L1);
  localparam logic signed [OUT_W-1:0] C_L3   = OUT_W'(Q16_L3);
  localparam logic signed [OUT_W-1:0] C_1U   = OUT_W'(Q64_U);
  localparam logic signed [OUT_W-1:0] C_3U   = OUT_W'(3 * Q64_U);
  localparam logic signed [OUT_W-1:0] C_5U   = OUT_W'(5 * Q64_U);
  localparam logic signed [OUT_W-1:0] C_7U   = OUT_W'(7 * Q64_U);

  localparam logic [1:0] K_DATA  = 2'd0;
  localparam logic [1:0] K_PILOT = 2'd1;
  localparam logic [1:0] K_NULL  = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Bins remaining after the current one; the emission index is its
  // complement, so the reset value 63 corresponds to bin counter 0.
  logic [5:0] rem_cnt;
  logic [5:0] idx;
  logic [5:0] cur_bin;
  logic [1:0] cur_kind;
  logic [2:0] bpsc_r;
  logic [6:0] lfsr;
  logic       lfsr_out;
  logic       pilot_neg;
  logic       bpsc_ok;
  logic       adv;
  logic       issue;
  logic       load;
  logic       in_ready_c;
  logic       sym_err_c;

  logic signed [OUT_W-1:0] map_i, map_q;
  logic signed [OUT_W-1:0] smp_i, smp_q;

  logic                    out_valid_r;
  logic signed [OUT_W-1:0] out_i_r, out_q_r;
  logic [5:0]              out_bin_r;
  logic [1:0]              out_kind_r;
  logic                    out_last_r;

  function automatic logic signed [OUT_W-1:0] sgn(
    input logic pos, input logic signed [OUT_W-1:0] mag);
    sgn = pos ? mag : -mag;
  endfunction

  function automatic logic signed [OUT_W-1:0] lvl16(input logic [1:0] b);
    lvl16 = sgn(b[1], b[0] ? C_L1 : C_L3);
  endfunction

  function automatic logic signed [OUT_W-1:0] lvl64(input logic [2:0] b);
    logic signed [OUT_W-1:0] mag;
    case (b[1:0])
      2'b00:   mag = C_7U;
      2'b01:   mag = C_5U;
      2'b11:   mag = C_3U;
      default: mag = C_1U;
    endcase
    lvl64 = sgn(b[2], mag);
  endfunction

  always_comb begin
    idx = ~rem_cnt;
`ifdef OFDM_MAPPER_FFTSHIFT_EN
    cur_bin = {~idx[5], idx[4:0]};
`else
    cur_bin = idx;
`endif
  end

  always_comb begin
    cur_kind = K_DATA;
    if (cur_bin == 6'd0 || (cur_bin >= 6'd27 && cur_bin <= 6'd37))
      cur_kind = K_NULL;
    else if (cur_bin == 6'd7 || cur_bin == 6'd21 ||
             cur_bin == 6'd43 || cur_bin == 6'd57)
      cur_kind = K_PILOT;
  end

  // Scrambler-style generator: output bit is x^7 xor x^4 of the register.
  assign lfsr_out  = lfsr[6] ^ lfsr[3];
  assign pilot_neg = lfsr_out ^ (cur_bin == 6'd21);

  assign bpsc_ok = (bus.sym_bpsc == 3'd1) || (bus.sym_bpsc == 3'd2) ||
                   (bus.sym_bpsc == 3'd4) || (bus.sym_bpsc == 3'd6);

  assign adv = !out_valid_r || bus.out_ready;

  always_comb begin
    map_i = '0;
    map_q = '0;
    case (bpsc_r)
      3'd1: map_i = sgn(bus.in_data[0], C_BPSK);
      3'd2: begin
        map_i = sgn(bus.in_data[1], C_QPSK);
        map_q = sgn(bus.in_data[0], C_QPSK);
      end
      3'd4: begin
        map_i = lvl16(bus.in_data[3:2]);
        map_q = lvl16(bus.in_data[1:0]);
      end
      3'd6: begin
        map_i = lvl64(bus.in_data[5:3]);
        map_q = lvl64(bus.in_data[2:0]);
      end
      default: begin
        map_i = '0;
        map_q = '0;
      end
    endcase
  end

  always_comb begin
    smp_i = '0;
    smp_q = '0;
    if (cur_kind == K_DATA) begin
      smp_i = map_i;
      smp_q = map_q;
    end else if (cur_kind == K_PILOT) begin
      smp_i = sgn(!pilot_neg, C_BPSK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    issue      = 1'b0;
    in_ready_c = 1'b0;
    sym_err_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.sym_start) begin
          if (bpsc_ok) begin
            load      = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            sym_err_c = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (cur_kind == K_DATA) begin
            in_ready_c = 1'b1;
            issue      = bus.in_valid;
          end else begin
            issue = 1'b1;
          end
          if (issue && rem_cnt == 6'd0) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_cnt     <= 6'd63;
      bpsc_r      <= 3'd0;
      lfsr        <= 7'h7f;
      out_valid_r <= 1'b0;
      out_i_r     <= '0;
      out_q_r     <= '0;
      out_bin_r   <= 6'd0;
      out_kind_r  <= 2'd0;
      out_last_r  <= 1'b0;
    end else begin
      if (load) begin
        bpsc_r  <= bus.sym_bpsc;
        rem_cnt <= 6'd63;
        if (bus.frame_start) lfsr <= 7'h7f;
      end
      if (issue) begin
        out_valid_r <= 1'b1;
        out_i_r     <= smp_i;
        out_q_r     <= smp_q;
        out_bin_r   <= cur_bin;
        out_kind_r  <= cur_kind;
        out_last_r  <= (rem_cnt == 6'd0);
        rem_cnt     <= rem_cnt - 6'd1;
        if (rem_cnt == 6'd0) lfsr <= {lfsr[5:0], lfsr_out};
      end else if (adv) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign bus.sym_ready = (state == ST_IDLE);
  assign bus.sym_err   = sym_err_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_i     = out_i_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.out_kind  = out_kind_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_ofdm_symbol_mapper.sv
// tb_ofdm_symbol_mapper
// Directed bench for ofdm_symbol_mapper in natural bin order.
module tb_ofdm_symbol_mapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_symbol_mapper_if #(.OUT_W(13)) bus ();
  ofdm_symbol_mapper #(.OUT_W(13)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [5:0]         din    [48];
  logic signed [12:0] s_i    [64];
  logic signed [12:0] s_q    [64];
  logic [5:0]         s_bin  [64];
  logic [1:0]         s_kind [64];
  logic               s_last [64];
  logic               s_rdy  [64];
  int n_out, n_in, stall_bin, stall_chg, stall_rdy, stall_done;
  bit timeout;

  task automatic set_din_alt();
    for (int k = 0; k < 48; k++) din[k] = {5'd0, k[0]};
  endtask

  task automatic start_symbol(input logic [2:0] bpsc, input logic frame);
    @(posedge clk); #1;
    bus.sym_start = 1'b1; bus.sym_bpsc = bpsc; bus.frame_start = frame;
    @(posedge clk); #1;
    bus.sym_start = 1'b0; bus.frame_start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = din[0]; bus.out_ready = 1'b1;
  endtask

  task automatic collect();
    logic hs;
    logic signed [12:0] hi, hq;
    logic [5:0] hb;
    n_out = 0; n_in = 0; stall_chg = 0; stall_rdy = 0; stall_done = 0; timeout = 0;
    for (int cyc = 0; cyc < 1000 && n_out < 64; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && stall_bin >= 0 && stall_done == 0 &&
          int'(bus.out_bin) == stall_bin) begin
        bus.out_ready = 1'b0;
        hi = bus.out_i; hq = bus.out_q; hb = bus.out_bin;
        for (int s = 0; s < 5; s++) begin
          #1;
          if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stall_rdy++;
          if (bus.out_i !== hi || bus.out_q !== hq || bus.out_bin !== hb) stall_chg++;
          @(negedge clk);
        end
        bus.out_ready = 1'b1; stall_done = 1;
        #1;
      end
      hs = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        s_i[n_out] = bus.out_i; s_q[n_out] = bus.out_q; s_bin[n_out] = bus.out_bin;
        s_kind[n_out] = bus.out_kind; s_last[n_out] = bus.out_last;
        s_rdy[n_out] = bus.sym_ready;
        n_out++;
      end
      @(posedge clk); #1;
      if (hs) begin
        n_in++;
        if (n_in < 48) bus.in_data = din[n_in];
        else bus.in_valid = 1'b0;
      end
    end
    if (n_out < 64) timeout = 1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_symbol(input logic [2:0] bpsc, input logic frame);
    start_symbol(bpsc, frame);
    collect();
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL symbol_timeout: got %0d samples want 64", n_out);
    end
  endtask

  task automatic test_reset();
    bus.frame_start = 0; bus.sym_start = 0; bus.sym_bpsc = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.sym_ready, bus.out_valid, bus.in_ready, bus.sym_err, bus.out_last} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000",
        {bus.sym_ready, bus.out_valid, bus.in_ready, bus.sym_err, bus.out_last});
    end
    total++;
    if (bus.out_i !== 13'sd0 || bus.out_q !== 13'sd0 || bus.out_bin !== 6'd0 || bus.out_kind !== 2'd0) begin
      bad++; $display("FAIL reset_payload: got i=%0d q=%0d bin=%0d kind=%0d want 0",
        bus.out_i, bus.out_q, bus.out_bin, bus.out_kind);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bpsk();
    int j, nlast, errs;
    logic signed [12:0] ei;
    logic [1:0] ek;
    set_din_alt();
    stall_bin = -1;
    run_symbol(3'd1, 1'b1);
    total++;
    if (n_in !== 48) begin bad++; $display("FAIL bpsk_inputs: got %0d want 48", n_in); end
    j = 0; errs = 0; nlast = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || (k >= 27 && k <= 37)) begin ek = 2'd2; ei = 0; end
      else if (k == 7 || k == 43 || k == 57) begin ek = 2'd1; ei = 13'sd2048; end
      else if (k == 21) begin ek = 2'd1; ei = -13'sd2048; end
      else begin ek = 2'd0; ei = din[j][0] ? 13'sd2048 : -13'sd2048; j++; end
      total++;
      if (s_bin[k] !== k[5:0] || s_kind[k] !== ek || s_i[k] !== ei || s_q[k] !== 13'sd0) begin
        bad++; errs++;
        $display("FAIL bpsk_bin%0d: got bin=%0d kind=%0d i=%0d q=%0d want bin=%0d kind=%0d i=%0d q=0",
          k, s_bin[k], s_kind[k], s_i[k], s_q[k], k, ek, ei);
      end
      if (s_last[k]) nlast++;
    end
    total++;
    if (s_last[63] !== 1'b1 || nlast !== 1) begin
      bad++; $display("FAIL bpsk_last: got last63=%0d count=%0d want 1/1", s_last[63], nlast);
    end
    total++;
    if (s_rdy[62] !== 1'b0 || s_rdy[63] !== 1'b1) begin
      bad++; $display("FAIL bpsk_sym_ready: got %0d,%0d want 0,1", s_rdy[62], s_rdy[63]);
    end
  endtask

  task automatic test_mapping();
    for (int k = 0; k < 48; k++) din[k] = 6'd0;
    din[0] = 6'b100_000; din[1] = 6'b011_110;
    stall_bin = -1;
    run_symbol(3'd6, 1'b0);
    total++;
    if (s_i[1] !== 13'sd2212 || s_q[1] !== -13'sd2212) begin
      bad++; $display("FAIL qam64_a: got (%0d,%0d) want (2212,-2212)", s_i[1], s_q[1]);
    end
    total++;
    if (s_i[2] !== -13'sd948 || s_q[2] !== 13'sd316) begin
      bad++; $display("FAIL qam64_b: got (%0d,%0d) want (-948,316)", s_i[2], s_q[2]);
    end
    total++;
    if (s_i[3] !== -13'sd2212 || s_q[3] !== -13'sd2212) begin
      bad++; $display("FAIL qam64_zero: got (%0d,%0d) want (-2212,-2212)", s_i[3], s_q[3]);
    end
    din[0] = 6'b00_1011; din[1] = 6'b11_0100;
    run_symbol(3'd4, 1'b0);
    total++;
    if (s_i[1] !== 13'sd1943 || s_q[1] !== 13'sd648) begin
      bad++; $display("FAIL qam16_a: got (%0d,%0d) want (1943,648)", s_i[1], s_q[1]);
    end
    total++;
    if (s_i[2] !== -13'sd648 || s_q[2] !== -13'sd1943) begin
      bad++; $display("FAIL qam16_b: got (%0d,%0d) want (-648,-1943)", s_i[2], s_q[2]);
    end
    din[0] = 6'b000001; din[1] = 6'b111110;
    run_symbol(3'd2, 1'b0);
    total++;
    if (s_i[1] !== -13'sd1448 || s_q[1] !== 13'sd1448) begin
      bad++; $display("FAIL qpsk_a: got (%0d,%0d) want (-1448,1448)", s_i[1], s_q[1]);
    end
    total++;
    if (s_i[2] !== 13'sd1448 || s_q[2] !== -13'sd1448) begin
      bad++; $display("FAIL qpsk_b: got (%0d,%0d) want (1448,-1448)", s_i[2], s_q[2]);
    end
  endtask

  task automatic test_stall();
    int order_err;
    set_din_alt();
    stall_bin = 12;
    run_symbol(3'd1, 1'b0);
    stall_bin = -1;
    total++;
    if (stall_done !== 1) begin bad++; $display("FAIL stall_seen: got %0d want 1", stall_done); end
    total++;
    if (stall_chg !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", stall_chg); end
    total++;
    if (stall_rdy !== 0) begin bad++; $display("FAIL stall_ready: got %0d violations want 0", stall_rdy); end
    total++;
    if (n_in !== 48) begin bad++; $display("FAIL stall_inputs: got %0d want 48", n_in); end
    order_err = 0;
    for (int k = 0; k < 64; k++) if (s_bin[k] !== k[5:0]) order_err++;
    total++;
    if (order_err !== 0) begin bad++; $display("FAIL stall_order: got %0d misordered want 0", order_err); end
    total++;
    if (s_i[12] !== -13'sd2048 || s_i[13] !== 13'sd2048) begin
      bad++; $display("FAIL stall_values: got %0d,%0d want -2048,2048", s_i[12], s_i[13]);
    end
  endtask

  task automatic test_pilot_seq();
    logic pos [6];
    logic signed [12:0] e;
    pos[0] = 1; pos[1] = 1; pos[2] = 1; pos[3] = 1; pos[4] = 0; pos[5] = 1;
    set_din_alt();
    stall_bin = -1;
    for (int s = 0; s < 6; s++) begin
      run_symbol(3'd1, (s == 0 || s == 5));
      e = pos[s] ? 13'sd2048 : -13'sd2048;
      total++;
      if (s_i[7] !== e) begin
        bad++; $display("FAIL pilot_sym%0d: got %0d want %0d", s, s_i[7], e);
      end
      if (s == 4) begin
        total++;
        if (s_i[21] !== 13'sd2048) begin
          bad++; $display("FAIL pilot21_sym4: got %0d want 2048", s_i[21]);
        end
      end
    end
  endtask

  task automatic test_bad_bpsc();
    int viol;
    @(posedge clk); #1;
    bus.sym_start = 1'b1; bus.sym_bpsc = 3'd3;
    @(negedge clk);
    total++;
    if (bus.sym_err !== 1'b1 || bus.sym_ready !== 1'b1) begin
      bad++; $display("FAIL bad_bpsc_err: got err=%0d rdy=%0d want 1,1", bus.sym_err, bus.sym_ready);
    end
    @(posedge clk); #1;
    bus.sym_start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.sym_err !== 1'b0) begin bad++; $display("FAIL bad_bpsc_pulse: got %0d want 0", bus.sym_err); end
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b1) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL bad_bpsc_idle: got %0d violations want 0", viol); end
    @(posedge clk); #1;
    bus.sym_start = 1'b1; bus.sym_bpsc = 3'd0;
    @(negedge clk);
    total++;
    if (bus.sym_err !== 1'b1) begin bad++; $display("FAIL bad_bpsc_zero: got %0d want 1", bus.sym_err); end
    @(posedge clk); #1;
    bus.sym_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    set_din_alt();
    stall_bin = -1;
    for (int s = 0; s < 3; s++) run_symbol(3'd1, 1'b0);
    start_symbol(3'd1, 1'b0);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_bin == 6'd20) found = 1;
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL rst_mid_reach: got 0 want bin 20 seen"); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.sym_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_drop: got v=%0d ir=%0d sr=%0d want 0,0,1",
        bus.out_valid, bus.in_ready, bus.sym_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_symbol(3'd1, 1'b0);
    total++;
    if (s_bin[0] !== 6'd0 || s_kind[0] !== 2'd2) begin
      bad++; $display("FAIL rst_mid_bin0: got bin=%0d kind=%0d want 0,2", s_bin[0], s_kind[0]);
    end
    total++;
    if (s_i[7] !== 13'sd2048) begin
      bad++; $display("FAIL rst_mid_p0: got %0d want 2048", s_i[7]);
    end
  endtask

  initial begin
    stall_bin = -1;
    test_reset();
    test_bpsk();
    test_mapping();
    test_stall();
    test_pilot_seq();
    test_bad_bpsc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ofdm_symbol_mapper.md
Name: ofdm_symbol_mapper

Overview:
Sequential 802.11a constellation mapper for a whole OFDM symbol. It accepts coded bit groups through a valid/ready handshake. It emits all 64 IFFT bins per symbol, inserting DC/guard nulls and the four pilots with per-symbol 127-length polarity. It sits between the interleaver and the IFFT, with per-symbol modulation and parametrised output width/amplitudes.

Parameters:
OUT_W, 13, signed output width of I and Q
A_BPSK, 2048, BPSK and pilot amplitude
A_QPSK, 1448, QPSK level
Q16_L1, 648, 16-QAM inner level
Q16_L3, 1943, 16-QAM outer level
Q64_U, 316, 64-QAM unit; levels are U, 3U, 5U, 7U

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  with sym_start, restarts pilot sequence at p0
sym_start  in  1  start-of-symbol request, honoured only when sym_ready=1
sym_bpsc  in  3  bits per subcarrier for the symbol: 1, 2, 4 or 6
sym_ready  out  1  high in IDLE
sym_err  out  1  one-cycle pulse on sym_start with illegal sym_bpsc
in_valid  in  1  data bit group valid
in_data  in  6  bit group, LSB-aligned, bits [bpsc-1:0] used
in_ready  out  1  data bit group accepted when in_valid and in_ready
out_valid  out  1  output sample valid
out_ready  in  1  downstream accept
out_i  out  OUT_W  real part, signed
out_q  out  OUT_W  imaginary part, signed
out_bin  out  6  IFFT bin index of the sample
out_kind  out  2  0 data, 1 pilot, 2 null
out_last  out  1  marks bin 63 (last sample of the symbol)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, bin counter 0, latched bpsc 0.
  - Pilot LFSR all-ones.
  - All outputs 0 except sym_ready=1.
- State IDLE:
  - sym_start with sym_bpsc in {1,2,4,6}: latch bpsc; if frame_start, load LFSR all-ones; go RUN, bin=0.
  - sym_start with other sym_bpsc: sym_err=1 for one cycle, remain IDLE.
- State RUN:
  - Output register advances when (!out_valid || out_ready).
  - Null bins (0, 27..37): issue (0,0) without consuming input.
  - Pilot bins: issue (±A_BPSK, 0) without consuming input.
    - Bins 7, 43, 57: +p.
    - Bin 21: -p.
  - Data bins (remaining 48): in_ready = advance condition; issue only on an input handshake. No handshake means no issue and the bin counter holds.
  - in_ready=0 on null/pilot bins and outside RUN.
- Latency: one cycle from input handshake (or from bin issue) to out_valid. out_valid and payload are held stable until out_ready.
- Bin 63 issued:
  - out_last=1.
  - LFSR steps once (x^7+x^4+1).
  - Return to IDLE; sym_ready rises the next cycle.
- Pilot polarity: p = +1 when current LFSR output bit is 0, -1 when 1. The sequence wraps after 127 symbols.
- Mapping (Gray; 1-bit = positive half-plane):
  - BPSK: I = bit0 ? +A : -A, Q = 0.
  - QPSK: I sign from bit1, Q sign from bit0.
  - 16-QAM: I from bits[3:2], Q from bits[1:0]; 00→-L3, 01→-L1, 11→+L1, 10→+L3.
  - 64-QAM: I from bits[5:3], Q from bits[2:0]; 000→-7U, 001→-5U, 011→-3U, 010→-U, 110→+U, 111→+3U, 101→+5U, 100→+7U.
- Amplitude constants are sign-extended/negated to OUT_W; amplitudes must fit OUT_W-1 magnitude bits (elaboration-time check).
- sym_start and frame_start are ignored in RUN.
- Unused in_data bits are ignored.

Optional Feature:
Macro: OFDM_MAPPER_FFTSHIFT_EN
- Defined: emission order is bins 32..63 then 0..31 (subcarrier -32..31 order). out_last marks bin 31. Null/pilot positions are unchanged by bin number.
- Undefined: natural bin order 0..63.

Test Plan:
1. BPSK after frame_start, in_data alternating 0,1, out_ready=1 → 64 samples, 48 inputs consumed.
   - Bin0 (0,0); bin1 I=-2048; bin2 I=+2048.
   - Bin7 I=+2048; bin21 I=-2048; bins 27..37 zero.
   - out_last at bin63; sym_ready=1 one cycle later.
2. 64-QAM inputs → required mappings:
   - 6'b100_000 → (2212,-2212).
   - 6'b011_110 → (-948,316).
   - 16-QAM 6'b00_1011 → (1943,648).
   - QPSK 2'b01 → (-1448,1448).
3. out_ready low 5 cycles at bin 12 → out_valid/out_i/out_q/out_bin stable, in_ready=0, no input lost; sequence resumes at bin 13.
4. Five consecutive symbols, frame_start on first → bin7 I = +2048 ×4, then -2048 on symbol 5. frame_start on symbol 6 restores +2048.
5. sym_start with sym_bpsc=3 → sym_err pulse one cycle, sym_ready stays 1, no output.
6. rst_n low at bin 20 → out_valid, in_ready drop immediately. After release: sym_ready=1, next symbol starts bin 0 with p0 polarity.
